timer_req_scheduler: RTL

- Avalon-MM master that shares one 16-bit-register interval timer among N requesters, each needing a one-shot delay of a programmable cycle count.
- Arbitrates round-robin and programs the timer (stop, period low/high, status clear, start with interrupt enable).
- Waits for the timer irq, clears the status, then returns a done pulse to the owning requester.
- Sits between hardware clients (UART timeout, debounce, etc.) and the timer's s1 slave port.

---
 rtl/timer_req_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/timer_req_scheduler.sv
// Shares one Avalon-MM interval timer among N one-shot delay requesters.
// Round-robin grant, programs the timer, waits for irq (or abort), reports done/aborted.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | no owner; round-robin search for a request
// W_STOP    | write control = STOP
// W_PL      | write period_l = L[15:0]
// W_PH      | write period_h = L[31:16]
// W_CLR     | write status (clear stale timeout)
// W_START   | write control = START | ITO
// WAIT      | timer running; wait for irq or owner abort
// W_ACK     | write status (clear timeout) after irq
// W_ABORT   | write control = STOP on abort
// ABORT_CLR | write status (clears a race timeout), report aborted
// DONE      | report done to owner
module timer_req_scheduler #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [32*N-1:0]    req_period,
  input  logic [N-1:0]       abort,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [N-1:0]       aborted,
  output logic               busy,
  output logic [IDX_W-1:0]   active_idx,
  output logic [2:0]         tm_address,
  output logic               tm_chipselect,
  output logic               tm_write_n,
  output logic [15:0]        tm_writedata,
  input  logic               tm_irq
);

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_PL, W_PH, W_CLR, W_START, WAIT, W_ACK, W_ABORT, ABORT_CLR, DONE
  } state_t;

  localparam logic [15:0] CTRL_STOP  = 16'h0008;
  localparam logic [15:0] CTRL_START = 16'h0005;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_len;
  logic              r_zero;
  logic [N-1:0]      r_gnt;
  logic [N-1:0]      r_done;
  logic [N-1:0]      r_aborted;
  logic              r_busy;
  logic [2:0]        r_addr;
  logic              r_cs;
  logic [15:0]       r_wdata;

  logic              w_found;
  logic [IDX_W-1:0]  w_pick;
  logic [31:0]       w_sel_period;
  logic              w_grant;
  logic              w_abort_act;
  logic              w_cs;
  logic [2:0]        w_addr;
  logic [15:0]       w_wdata;

  // Round-robin search starting at r_rr, wrapping at N.
  always_comb begin
    w_found      = 1'b0;
    w_pick       = '0;
    w_sel_period = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(r_rr) + k;
      if (j >= N) j = j - N;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(j);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (int'(w_pick) == k) w_sel_period = req_period[32*k +: 32];
    end
  end

  assign w_abort_act = abort[r_idx];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
          w_next  = (w_sel_period == 32'd0) ? DONE : W_STOP;
        end
      end
      W_STOP:    w_next = W_PL;
      W_PL:      w_next = W_PH;
      W_PH:      w_next = W_CLR;
      W_CLR:     w_next = W_START;
      W_START:   w_next = WAIT;
      WAIT: begin
        if (tm_irq)           w_next = W_ACK;
        else if (w_abort_act) w_next = W_ABORT;
      end
      W_ACK:     w_next = DONE;
      W_ABORT:   w_next = ABORT_CLR;
      ABORT_CLR: w_next = IDLE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Bus fields are decoded from the next state so the registered strobe lines up with the state.
  always_comb begin
    w_cs    = 1'b0;
    w_addr  = 3'd0;
    w_wdata = 16'h0000;
    case (w_next)
      W_STOP:    begin w_cs = 1'b1; w_addr = 3'd1; w_wdata = CTRL_STOP;     end
      W_PL:      begin w_cs = 1'b1; w_addr = 3'd2; w_wdata = r_len[15:0];   end
      W_PH:      begin w_cs = 1'b1; w_addr = 3'd3; w_wdata = r_len[31:16];  end
      W_CLR:     begin w_cs = 1'b1; w_addr = 3'd0; w_wdata = 16'h0000;      end
      W_START:   begin w_cs = 1'b1; w_addr = 3'd1; w_wdata = CTRL_START;    end
      W_ACK:     begin w_cs = 1'b1; w_addr = 3'd0; w_wdata = 16'h0000;      end
      W_ABORT:   begin w_cs = 1'b1; w_addr = 3'd1; w_wdata = CTRL_STOP;     end
      ABORT_CLR: begin w_cs = 1'b1; w_addr = 3'd0; w_wdata = 16'h0000;      end
      default:   begin w_cs = 1'b0; w_addr = 3'd0; w_wdata = 16'h0000;      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr      <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_zero    <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_aborted <= '0;
      r_busy    <= 1'b0;
      r_addr    <= 3'd0;
      r_cs      <= 1'b0;
      r_wdata   <= 16'h0000;
    end else begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_aborted <= '0;
      if (w_grant) begin
        r_idx  <= w_pick;
        r_len  <= w_sel_period - 32'd1;
        r_zero <= (w_sel_period == 32'd0);
        r_rr   <= (int'(w_pick) == N-1) ? '0 : w_pick + 1'b1;
        r_gnt  <= N'(1) << w_pick;
      end
      // Timed path reports in the DONE cycle; the zero-period path one cycle after its grant.
      if (r_state == W_ACK || (r_state == DONE && r_zero))
        r_done <= N'(1) << r_idx;
      if (r_state == ABORT_CLR)
        r_aborted <= N'(1) << r_idx;
      r_busy  <= (w_next != IDLE);
      r_cs    <= w_cs;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  assign gnt           = r_gnt;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign busy          = r_busy;
  assign active_idx    = r_idx;
  assign tm_address    = r_addr;
  assign tm_chipselect = r_cs;
  assign tm_write_n    = ~r_cs;
  assign tm_writedata  = r_wdata;

endmodule
